// File: rtl/serial_subtractor_pkg.sv
// Shared types for the bit-serial subtractor.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package serial_subtractor_pkg;

    // Control states. IDLE accepts operands, RUN produces one difference
    // bit per clock, and DONE holds the result until the consumer takes it.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sub_state_t;

endpackage

// File: rtl/serial_subtractor_full_adder.sv
// Single-bit full adder cell: sum and carry of three input bits.
// Latency: purely combinational.
// Backpressure: none; there is no handshake.
// Ports: operand_1, operand_2, carry_in -> sum, carry_out.
module full_adder (
    input  logic operand_1,
    input  logic operand_2,
    input  logic carry_in,
    output logic sum,
    output logic carry_out
);

    assign sum       = operand_1 ^ operand_2 ^ carry_in;
    assign carry_out = (operand_1 & operand_2) | (carry_in & (operand_1 ^ operand_2));

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor (minuend - subtrahend), LSB first.
// Latency: accept on edge N gives result_valid after edge N+WIDTH.
// Backpressure: result held in DONE until result_ready; start_ready only in IDLE.
// Ports: start_valid/start_ready with minuend/subtrahend in; result_valid/
//        result_ready with difference, borrow_out, overflow out.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] minuend,
    input  logic [WIDTH-1:0] subtrahend,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [WIDTH-1:0] difference,
    output logic             borrow_out,
    output logic             overflow
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    sub_state_t       state_q;
    sub_state_t       state_d;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_q;
    logic             ovf_q;

    logic             fa_sum;
    logic             fa_carry;
    logic             last_bit;
    logic             accept;

    // a - b == a + ~b + 1: invert the subtrahend bit, seed carry with 1.
    full_adder u_full_adder (
        .operand_1 (a_q[0]),
        .operand_2 (~b_q[0]),
        .carry_in  (carry_q),
        .sum       (fa_sum),
        .carry_out (fa_carry)
    );

    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));
    assign accept   = (state_q == IDLE) && start_valid;

    // Handshake outputs decode the state register only.
    assign start_ready  = (state_q == IDLE);
    assign result_valid = (state_q == DONE);

    assign difference = diff_q;
    assign borrow_out = borrow_q;
    assign overflow   = ovf_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_valid)  state_d = RUN;
            RUN:     if (last_bit)     state_d = DONE;
            DONE:    if (result_ready) state_d = IDLE;
            default:                   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            a_q      <= '0;
            b_q      <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else if (accept) begin
            a_q     <= minuend;
            b_q     <= subtrahend;
            carry_q <= 1'b1;
            cnt_q   <= '0;
            diff_q  <= '0;
        end else if (state_q == RUN) begin
            diff_q  <= {fa_sum, diff_q[WIDTH-1:1]};
            carry_q <= fa_carry;
            a_q     <= {1'b0, a_q[WIDTH-1:1]};
            b_q     <= {1'b0, b_q[WIDTH-1:1]};
            cnt_q   <= cnt_q + CNT_W'(1);
            if (last_bit) begin
                // Carry into the MSB differs from carry out of it on signed
                // overflow; a missing final carry means an unsigned borrow.
                ovf_q    <= carry_q ^ fa_carry;
                borrow_q <= ~fa_carry;
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

    localparam int WIDTH = 8;
    localparam int RW    = WIDTH + 2;

    logic             clock;
    logic             reset_n;
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] minuend;
    logic [WIDTH-1:0] subtrahend;
    logic             result_valid;
    logic             result_ready;
    logic [WIDTH-1:0] difference;
    logic             borrow_out;
    logic             overflow;

    int n_checks = 0;
    int n_errors = 0;

    // Scoreboard entries: {difference, borrow_out, overflow}.
    logic [RW-1:0] sb_q[$];
    logic [RW-1:0] last_res;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .minuend      (minuend),
        .subtrahend   (subtrahend),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .difference   (difference),
        .borrow_out   (borrow_out),
        .overflow     (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [RW-1:0] model(input logic [WIDTH-1:0] m, input logic [WIDTH-1:0] s);
        logic [WIDTH-1:0] d;
        logic             b;
        logic             v;
        d = m - s;
        b = (m < s);
        v = (m[WIDTH-1] != s[WIDTH-1]) && (d[WIDTH-1] != m[WIDTH-1]);
        return {d, b, v};
    endfunction

    // Present operands and take the accept edge; returns 1ns after it.
    task automatic start_op(input logic [WIDTH-1:0] m, input logic [WIDTH-1:0] s);
        start_valid = 1'b1;
        minuend     = m;
        subtrahend  = s;
        chk("start_ready_before_accept", start_ready, 1);
        @(posedge clock);
        #1;
        start_valid = 1'b0;
        minuend     = WIDTH'($urandom);
        subtrahend  = WIDTH'($urandom);
        sb_q.push_back(model(m, s));
    endtask

    // Called 1ns after the accept edge; checks latency and result fields.
    task automatic wait_result();
        for (int k = 1; k <= WIDTH; k++) begin
            @(posedge clock);
            #1;
            if (k < WIDTH) chk("valid_too_early", result_valid, 0);
        end
        chk("valid_at_n_plus_width", result_valid, 1);
        chk("start_ready_in_done", start_ready, 0);
        if (sb_q.size() == 0) begin
            chk("scoreboard_empty", 1, 0);
            last_res = '0;
        end else begin
            last_res = sb_q.pop_front();
            chk("difference", difference, last_res[RW-1:2]);
            chk("borrow_out", borrow_out, last_res[1]);
            chk("overflow",   overflow,   last_res[0]);
        end
    endtask

    task automatic release_result();
        result_ready = 1'b1;
        @(posedge clock);
        #1;
        result_ready = 1'b0;
        chk("idle_after_handshake", start_ready, 1);
        chk("valid_cleared", result_valid, 0);
    endtask

    task automatic run_op(input logic [WIDTH-1:0] m, input logic [WIDTH-1:0] s);
        start_op(m, s);
        wait_result();
        release_result();
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n      = 1'b0;
        start_valid  = 1'b0;
        result_ready = 1'b0;
        minuend      = '0;
        subtrahend   = '0;
        #12;
        chk("reset_start_ready",  start_ready,  1);
        chk("reset_result_valid", result_valid, 0);
        chk("reset_difference",   difference,   0);
        chk("reset_borrow",       borrow_out,   0);
        chk("reset_overflow",     overflow,     0);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        run_op(8'd100, 8'd58);
        run_op(8'd5,   8'd10);
        run_op(8'h80,  8'h01);
        run_op(8'h7F,  8'hFF);
        run_op(8'h37,  8'h37);
        for (int i = 0; i < 4; i++) run_op(WIDTH'($urandom), WIDTH'($urandom));

        // Backpressure: hold DONE with start_valid asserted and shifting operands.
        start_op(8'hA5, 8'h3C);
        wait_result();
        start_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            minuend    = WIDTH'($urandom);
            subtrahend = WIDTH'($urandom);
            @(posedge clock);
            #1;
            chk("bp_valid_held",  result_valid, 1);
            chk("bp_no_accept",   start_ready,  0);
            chk("bp_diff_stable", difference,   last_res[RW-1:2]);
            chk("bp_borrow_stable", borrow_out, last_res[1]);
            chk("bp_ovf_stable",  overflow,     last_res[0]);
        end
        result_ready = 1'b1;
        minuend      = 8'd33;
        subtrahend   = 8'd77;
        @(posedge clock);
        #1;
        result_ready = 1'b0;
        chk("bp_idle_after_release", start_ready, 1);
        sb_q.push_back(model(8'd33, 8'd77));
        @(posedge clock);
        #1;
        start_valid = 1'b0;
        chk("bp_accept_next_cycle", start_ready, 0);
        wait_result();
        release_result();

        // Reset during the third RUN bit cycle.
        start_op(8'hFF, 8'h00);
        @(posedge clock);
        #1;
        @(posedge clock);
        #1;
        chk("mid_run_not_valid", result_valid, 0);
        #3;
        reset_n = 1'b0;
        sb_q.delete();
        #1;
        chk("abort_result_valid", result_valid, 0);
        chk("abort_start_ready",  start_ready,  1);
        chk("abort_difference",   difference,   0);
        @(posedge clock);
        #2;
        reset_n = 1'b1;
        run_op(8'h00, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial two's-complement subtractor computing difference = minuend - subtrahend, LSB first, one bit per clock. Each step uses one full_adder cell with the subtrahend bit inverted and the carry seeded to 1. Operands enter and results leave through valid/ready handshakes. The block is the area-minimal subtract path for datapaths where latency is cheap.

Parameters:
WIDTH, 8, operand and result width in bits; legal range WIDTH >= 2.

Ports:
clock  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
start_valid  input  1  operands presented
start_ready  output  1  block can accept operands
minuend  input  WIDTH  first operand, sampled on accept
subtrahend  input  WIDTH  second operand, sampled on accept
result_valid  output  1  result fields valid
result_ready  input  1  consumer accepts the result
difference  output  WIDTH  minuend - subtrahend, modulo 2^WIDTH
borrow_out  output  1  unsigned borrow: 1 iff minuend < subtrahend
overflow  output  1  signed overflow of the two's-complement subtraction

Behaviour:
- One clock domain. Reset is asynchronous and active-low: reset_n low immediately forces state IDLE and clears all registers.
- Reset values: start_ready=1, result_valid=0, difference=0, borrow_out=0, overflow=0. No transfer occurs while reset_n is low.
- States: IDLE, RUN, DONE.
  - start_ready = (state==IDLE).
  - result_valid = (state==DONE).
  - Both outputs are decoded from the state register and never from inputs.
- IDLE:
  - Accept occurs on an edge with start_valid && start_ready.
  - On accept: A <= minuend, B <= subtrahend, carry <= 1, bit counter <= 0, difference register <= 0, state -> RUN.
- RUN, on each edge:
  - Compute s, c = full_adder(A[0], ~B[0], carry).
  - difference <= {s, difference[WIDTH-1:1]}.
  - carry <= c. A and B shift right by one.
  - Counter increments. Counter width is $clog2(WIDTH).
  - On the edge where counter==WIDTH-1:
    - Additionally register overflow <= carry ^ c, where carry is the carry into the MSB.
    - borrow_out <= ~c.
    - state -> DONE.
- Latency: accept on edge N means result_valid is high after edge N+WIDTH. RUN lasts exactly WIDTH cycles regardless of operand values.
- DONE:
  - difference, borrow_out and overflow are held stable until result_valid && result_ready.
  - On that edge, state -> IDLE.
  - start_valid is ignored in DONE: start_ready is 0, so there is no same-cycle re-accept. The earliest next accept is one cycle after the result handshake.
- The difference register shifts visibly during RUN. difference, borrow_out and overflow are guaranteed only while result_valid=1. In IDLE they hold the last result.
- Operand inputs may change freely after the accept edge without effect.
- Reset during RUN or DONE aborts the operation. The result is discarded with no partial output. After reset_n rises the block is in IDLE and ready.
- Equal operands give difference=0, borrow_out=0, overflow=0.

Decomposition:
- Package serial_subtractor_pkg holds the state enum typedef (IDLE, RUN, DONE). The counter width is derived locally with $clog2(WIDTH).
- Sub-module: one instance of the team's existing full_adder cell:
  - operand_1 = A[0]
  - operand_2 = ~B[0]
  - carry_in = carry register
- All remaining logic (FSM, shift registers, counter) lives in serial_subtractor itself.

Test Plan:
- Basic, WIDTH=8: minuend=100, subtrahend=58, accept on edge N -> result_valid rises after edge N+8; difference=42, borrow_out=0, overflow=0.
- Unsigned borrow: 5 - 10 -> difference=8'hFB, borrow_out=1, overflow=0.
- Signed overflow, negative side: 8'h80 - 8'h01 -> difference=8'h7F, borrow_out=0, overflow=1.
- Signed overflow, positive side: 8'h7F - 8'hFF -> difference=8'h80, borrow_out=1, overflow=1.
- Backpressure: result_ready held 0 for 5 cycles in DONE while start_valid=1 with changing operands -> outputs stable, start_ready=0, no new accept. After result_ready=1 -> IDLE; the next accept happens exactly one cycle later.
- Reset mid-RUN, on the 3rd bit cycle:
  - Asynchronously, result_valid=0, start_ready=1, difference=0.
  - A subsequent 0 - 0 -> difference=0, borrow_out=0, overflow=0 after 8 cycles.
